// File: rtl/wtile_pkg.sv
// Shared types and width helpers for the W-tile stream writer.
package wtile_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } wsw_state_e;

   typedef enum logic {
      ORDER_ROW = 1'b0,
      ORDER_K   = 1'b1
   } order_e;

   localparam int unsigned WSW_DATA_W = 32;

   // Reference entry layout at the default word width.
   typedef struct packed {
      logic [WSW_DATA_W-1:0]   data;
      logic [WSW_DATA_W/8-1:0] strb;
      logic                    last;
   } wsw_entry_t;

   // Index width with a floor of one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wtile_wr_fifo.sv
// Registered synchronous FIFO; push on full is accepted only when a pop frees a slot.
module wtile_wr_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/wtile_stream_writer.sv
// Drains a valid/ready word stream into the W SRAM CPU write port with tile address generation.
module wtile_stream_writer
   import wtile_pkg::*;
#(
   parameter int unsigned M          = 8,
   parameter int unsigned KMAX       = 1024,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned BYTE_W     = DATA_W / 8,
   parameter int unsigned ROW_W      = idx_w(M),
   parameter int unsigned K_W        = idx_w(KMAX),
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic [ROW_W:0]    cfg_rows,
   input  logic [K_W:0]      cfg_klen,
   input  logic              cfg_order,
   output logic              busy,
   output logic              done,
   output logic              err_cfg,
   output logic              err_last,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [BYTE_W-1:0] s_strb,
   input  logic              s_last,
   input  logic              wr_stall,
   output logic              cpu_w_we,
   output logic [ROW_W-1:0]  cpu_w_row,
   output logic [K_W-1:0]    cpu_w_k,
   output logic [DATA_W-1:0] cpu_w_wdata,
   output logic [BYTE_W-1:0] cpu_w_wmask
);

   localparam int unsigned TOT_W = ROW_W + K_W + 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [BYTE_W-1:0] strb;
      logic              last;
   } entry_t;

   wsw_state_e        state_q, state_d;
   order_e            order_q;
   logic [ROW_W:0]    rows_q;
   logic [K_W:0]      klen_q;
   logic [TOT_W-1:0]  total_q, in_cnt_q, out_cnt_q;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [K_W-1:0]    k_q, k_d;
   logic              err_cfg_q, err_last_q;
   logic              we_q;
   logic [ROW_W-1:0]  wr_row_q;
   logic [K_W-1:0]    wr_k_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BYTE_W-1:0] wmask_q;

   entry_t push_entry, pop_entry;
   logic   fifo_full, fifo_empty;
   logic   push, pop, last_pop, cfg_legal;

   assign cfg_legal = (cfg_rows != '0) && (cfg_rows <= (ROW_W + 1)'(M)) &&
                      (cfg_klen != '0) && (cfg_klen <= (K_W + 1)'(KMAX));

   assign s_ready    = (state_q == RUN) && !fifo_full && (in_cnt_q < total_q);
   assign push       = s_valid && s_ready;
   assign pop        = (state_q == RUN) && !fifo_empty && !wr_stall;
   assign last_pop   = pop && (out_cnt_q == total_q - 1'b1);
   assign push_entry = '{data: s_data, strb: s_strb, last: s_last};

   wtile_wr_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (pop_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Inner index wraps at its bound and carries into the outer one.
   always_comb begin
      row_d = row_q;
      k_d   = k_q;
      if (order_q == ORDER_ROW) begin
         if ({1'b0, k_q} == klen_q - 1'b1) begin
            k_d   = '0;
            row_d = row_q + 1'b1;
         end else begin
            k_d = k_q + 1'b1;
         end
      end else begin
         if ({1'b0, row_q} == rows_q - 1'b1) begin
            row_d = '0;
            k_d   = k_q + 1'b1;
         end else begin
            row_d = row_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cfg_start && cfg_legal) state_d = RUN;
         RUN:     if (last_pop) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         order_q    <= ORDER_ROW;
         rows_q     <= '0;
         klen_q     <= '0;
         total_q    <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         row_q      <= '0;
         k_q        <= '0;
         err_cfg_q  <= 1'b0;
         err_last_q <= 1'b0;
         we_q       <= 1'b0;
         wr_row_q   <= '0;
         wr_k_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
      end else begin
         state_q   <= state_d;
         err_cfg_q <= 1'b0;
         we_q      <= pop;
         if ((state_q == IDLE) && cfg_start) begin
            if (cfg_legal) begin
               rows_q     <= cfg_rows;
               klen_q     <= cfg_klen;
               order_q    <= order_e'(cfg_order);
               total_q    <= TOT_W'(cfg_rows) * TOT_W'(cfg_klen);
               in_cnt_q   <= '0;
               out_cnt_q  <= '0;
               row_q      <= '0;
               k_q        <= '0;
               err_last_q <= 1'b0;
            end else begin
               err_cfg_q <= 1'b1;
            end
         end
         if (push) in_cnt_q <= in_cnt_q + 1'b1;
         if (pop) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            row_q     <= row_d;
            k_q       <= k_d;
            wr_row_q  <= row_q;
            wr_k_q    <= k_q;
            wdata_q   <= pop_entry.data;
            wmask_q   <= pop_entry.strb;
            // Count governs the tile end; a misplaced last only flags.
            if (pop_entry.last != (out_cnt_q == total_q - 1'b1)) err_last_q <= 1'b1;
         end
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign err_cfg     = err_cfg_q;
   assign err_last    = err_last_q;
   assign cpu_w_we    = we_q;
   assign cpu_w_row   = wr_row_q;
   assign cpu_w_k     = wr_k_q;
   assign cpu_w_wdata = wdata_q;
   assign cpu_w_wmask = wmask_q;

endmodule

// File: tb/tb_wtile_stream_writer.sv
// Scoreboard bench: expected writes are queued at stimulus time, a monitor checks each write.
module tb_wtile_stream_writer;

   localparam int M      = 8;
   localparam int KMAX   = 1024;
   localparam int DATA_W = 32;
   localparam int BYTE_W = 4;
   localparam int ROW_W  = 3;
   localparam int K_W    = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_start = 1'b0;
   logic [ROW_W:0]    cfg_rows = '0;
   logic [K_W:0]      cfg_klen = '0;
   logic              cfg_order = 1'b0;
   logic              busy, done, err_cfg, err_last;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic [BYTE_W-1:0] s_strb = '0;
   logic              s_last = 1'b0;
   logic              wr_stall = 1'b0;
   logic              cpu_w_we;
   logic [ROW_W-1:0]  cpu_w_row;
   logic [K_W-1:0]    cpu_w_k;
   logic [DATA_W-1:0] cpu_w_wdata;
   logic [BYTE_W-1:0] cpu_w_wmask;

   always #5 clk = ~clk;

   wtile_stream_writer #(
      .M          (M),
      .KMAX       (KMAX),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_start   (cfg_start),
      .cfg_rows    (cfg_rows),
      .cfg_klen    (cfg_klen),
      .cfg_order   (cfg_order),
      .busy        (busy),
      .done        (done),
      .err_cfg     (err_cfg),
      .err_last    (err_last),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_strb      (s_strb),
      .s_last      (s_last),
      .wr_stall    (wr_stall),
      .cpu_w_we    (cpu_w_we),
      .cpu_w_row   (cpu_w_row),
      .cpu_w_k     (cpu_w_k),
      .cpu_w_wdata (cpu_w_wdata),
      .cpu_w_wmask (cpu_w_wmask)
   );

   typedef struct packed {
      logic [ROW_W-1:0]  row;
      logic [K_W-1:0]    k;
      logic [DATA_W-1:0] data;
      logic [BYTE_W-1:0] mask;
      logic              done;
   } wr_t;

   wr_t exp_q[$];
   wr_t act, exp_e;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  n_wr  = 0;

   function automatic logic [BYTE_W-1:0] strb_of(input logic [DATA_W-1:0] d);
      return d[3:0] ^ 4'h9;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (cpu_w_we) begin
            n_wr++;
            act = {cpu_w_row, cpu_w_k, cpu_w_wdata, cpu_w_wmask, done};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: row=%0d k=%0d data=%0h", cpu_w_row, cpu_w_k,
                        cpu_w_wdata);
            end else begin
               exp_e = exp_q.pop_front();
               if (act !== exp_e)
                  $display("FAIL write: got row=%0d k=%0d data=%0h mask=%0h done=%0b want row=%0d k=%0d data=%0h mask=%0h done=%0b",
                           act.row, act.k, act.data, act.mask, act.done,
                           exp_e.row, exp_e.k, exp_e.data, exp_e.mask, exp_e.done);
               if (act !== exp_e) n_bad++;
            end
         end else if (done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_without_write: got done=1 we=0 want done=0");
         end
      end
   end

   // Expected writes in stream order; nested loops give the tile walk order.
   task automatic expect_tile(input int rows, input int klen, input int order, input int base);
      int total = rows * klen;
      int i;
      wr_t e;
      if (order == 0) begin
         for (int r = 0; r < rows; r++)
            for (int k = 0; k < klen; k++) begin
               i = r * klen + k;
               e = {ROW_W'(r), K_W'(k), DATA_W'(base + i), strb_of(DATA_W'(base + i)),
                    (i == total - 1)};
               exp_q.push_back(e);
            end
      end else begin
         for (int k = 0; k < klen; k++)
            for (int r = 0; r < rows; r++) begin
               i = k * rows + r;
               e = {ROW_W'(r), K_W'(k), DATA_W'(base + i), strb_of(DATA_W'(base + i)),
                    (i == total - 1)};
               exp_q.push_back(e);
            end
      end
   endtask

   task automatic start(input logic [ROW_W:0] rows, input logic [K_W:0] klen, input logic ord);
      cfg_rows  = rows;
      cfg_klen  = klen;
      cfg_order = ord;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic send_word(input int d, input logic last);
      int n = 0;
      s_valid = 1'b1;
      s_data  = DATA_W'(d);
      s_strb  = strb_of(DATA_W'(d));
      s_last  = last;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("send_timeout", 64'(s_ready), 64'd1);
      end else begin
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int wbase;
      int n;
      repeat (2) @(negedge clk);
      check("reset_outputs", {busy, done, err_cfg, err_last, s_ready, cpu_w_we, cpu_w_row,
                              cpu_w_k, cpu_w_wdata, cpu_w_wmask}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Row-major 2x3
      start(4'd2, 11'd3, 1'b0);
      check("t1_busy", 64'(busy), 64'd1);
      expect_tile(2, 3, 0, 'h10);
      for (int i = 0; i < 6; i++) send_word('h10 + i, (i == 5));
      drain();
      check("t1_err_last", 64'(err_last), 64'd0);
      check("t1_busy_end", 64'(busy), 64'd0);

      // K-major 3x2
      start(4'd3, 11'd2, 1'b1);
      expect_tile(3, 2, 1, 'h20);
      for (int i = 0; i < 6; i++) send_word('h20 + i, (i == 5));
      drain();
      check("t2_err_last", 64'(err_last), 64'd0);

      // Stall: FIFO fills after four accepts, nothing written while stalled
      wr_stall = 1'b1;
      start(4'd1, 11'd8, 1'b0);
      expect_tile(1, 8, 0, 'h30);
      wbase = n_wr;
      for (int i = 0; i < 4; i++) send_word('h30 + i, 1'b0);
      check("t3_sready_full", 64'(s_ready), 64'd0);
      @(negedge clk);
      check("t3_no_write_stalled", 64'(n_wr - wbase), 64'd0);
      wr_stall = 1'b0;
      for (int i = 4; i < 8; i++) send_word('h30 + i, (i == 7));
      drain();

      // Illegal configurations
      start(4'd0, 11'd4, 1'b0);
      check("t4_err_cfg_rows0", 64'(err_cfg), 64'd1);
      check("t4_busy_rows0", 64'(busy), 64'd0);
      @(negedge clk);
      check("t4_err_cfg_pulse", 64'(err_cfg), 64'd0);
      start(4'd2, 11'(KMAX + 1), 1'b0);
      check("t4_err_cfg_klen", 64'(err_cfg), 64'd1);
      check("t4_busy_klen", 64'(busy), 64'd0);
      start(4'd9, 11'd1, 1'b0);
      check("t4_err_cfg_rows9", 64'(err_cfg), 64'd1);
      repeat (3) @(negedge clk);
      check("t4_busy_after", 64'(busy), 64'd0);

      // Misplaced last on word 2 of 4; extra words are refused
      start(4'd1, 11'd4, 1'b0);
      expect_tile(1, 4, 0, 'h40);
      for (int i = 0; i < 4; i++) send_word('h40 + i, (i == 1));
      s_valid = 1'b1;
      s_data  = 32'h99;
      s_last  = 1'b1;
      check("t5_sready_over", 64'(s_ready), 64'd0);
      @(negedge clk);
      check("t5_sready_over2", 64'(s_ready), 64'd0);
      s_valid = 1'b0;
      s_last  = 1'b0;
      drain();
      check("t5_err_last", 64'(err_last), 64'd1);

      // Reset mid-tile after three writes
      start(4'd2, 11'd3, 1'b0);
      check("t6_err_last_clr", 64'(err_last), 64'd0);
      for (int i = 0; i < 3; i++) exp_q.push_back({ROW_W'(0), K_W'(i), DATA_W'('h50 + i),
                                                   strb_of(DATA_W'('h50 + i)), 1'b0});
      for (int i = 0; i < 3; i++) send_word('h50 + i, 1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t6_three_written", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b0;
      #1;
      check("t6_reset_outputs", {busy, done, err_cfg, err_last, s_ready, cpu_w_we, cpu_w_row,
                                 cpu_w_k, cpu_w_wdata, cpu_w_wmask}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start(4'd1, 11'd2, 1'b0);
      expect_tile(1, 2, 0, 'h60);
      for (int i = 0; i < 2; i++) send_word('h60 + i, (i == 1));
      drain();
      check("t6_err_last", 64'(err_last), 64'd0);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
